// File: rtl/mem_stage_unit.sv
// MEM stage: retires AGEX-latched instructions, driving loads/stores through a valid/ready data port.
// Latency: 1 cycle for non-memory/misaligned ops; stores 1 after handshake; loads 1 after response.
module mem_stage_unit #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           in_memop,
  input  logic [DBITS-1:0]     in_addr,
  input  logic [DBITS-1:0]     in_wdata,
  input  logic [REGNOBITS-1:0] in_rd,
  input  logic                 in_reg_wr,
  input  logic [DBITS-1:0]     in_pc,
  output logic                 in_ready,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [DBITS-1:0]     dmem_req_addr,
  output logic [DBITS-1:0]     dmem_req_wdata,
  output logic [3:0]           dmem_req_be,
  input  logic                 dmem_resp_valid,
  input  logic [DBITS-1:0]     dmem_resp_rdata,
  output logic                 out_valid,
  output logic [REGNOBITS-1:0] out_rd,
  output logic [DBITS-1:0]     out_wdata,
  output logic                 out_reg_wr,
  output logic [DBITS-1:0]     out_pc,
  output logic [1:0]           out_exc,
  output logic                 fwd_valid,
  output logic [REGNOBITS-1:0] fwd_rd,
  output logic [DBITS-1:0]     fwd_value,
  output logic                 load_pending,
  output logic [REGNOBITS-1:0] load_pending_rd
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_MISALGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;

  function automatic logic op_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic op_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic op_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  logic [1:0]           state;
  logic [CW-1:0]        wait_cnt;
  logic [3:0]           cap_op;
  logic [DBITS-1:0]     cap_addr;
  logic [DBITS-1:0]     cap_wdata;
  logic [REGNOBITS-1:0] cap_rd;
  logic                 cap_reg_wr;
  logic [DBITS-1:0]     cap_pc;

  logic                 in_mem;
  logic                 in_misaligned;
  logic [7:0]           sel_byte;
  logic [15:0]          sel_half;
  logic [DBITS-1:0]     load_value;

  assign in_mem        = op_load(in_memop) | op_store(in_memop);
  assign in_misaligned = (op_half(in_memop) & in_addr[0]) |
                         (op_word(in_memop) & (in_addr[1:0] != 2'b00));

  assign in_ready       = (state == IDLE);
  assign dmem_req_valid = (state == REQ);
  assign dmem_req_we    = op_store(cap_op);
  assign dmem_req_addr  = {cap_addr[DBITS-1:2], 2'b00};

  // Lane formatting: narrow stores are replicated so the memory picks lanes purely by byte enable.
  always_comb begin
    dmem_req_wdata = cap_wdata;
    dmem_req_be    = 4'b1111;
    if (op_half(cap_op)) begin
      dmem_req_wdata = {(DBITS/16){cap_wdata[15:0]}};
      dmem_req_be    = cap_addr[1] ? 4'b1100 : 4'b0011;
    end else if (!op_word(cap_op)) begin
      dmem_req_wdata = {(DBITS/8){cap_wdata[7:0]}};
      dmem_req_be    = 4'b0001 << cap_addr[1:0];
    end
  end

  always_comb begin
    case (cap_addr[1:0])
      2'd0:    sel_byte = dmem_resp_rdata[7:0];
      2'd1:    sel_byte = dmem_resp_rdata[15:8];
      2'd2:    sel_byte = dmem_resp_rdata[23:16];
      default: sel_byte = dmem_resp_rdata[31:24];
    endcase
    sel_half = cap_addr[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    case (cap_op)
      OP_LB:   load_value = {{(DBITS-8){sel_byte[7]}}, sel_byte};
      OP_LBU:  load_value = {{(DBITS-8){1'b0}}, sel_byte};
      OP_LH:   load_value = {{(DBITS-16){sel_half[15]}}, sel_half};
      OP_LHU:  load_value = {{(DBITS-16){1'b0}}, sel_half};
      default: load_value = dmem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_op     <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_rd     <= '0;
      cap_reg_wr <= 1'b0;
      cap_pc     <= '0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_wdata  <= '0;
      out_reg_wr <= 1'b0;
      out_pc     <= '0;
      out_exc    <= EXC_NONE;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_mem || in_misaligned) begin
              out_valid  <= 1'b1;
              out_rd     <= in_rd;
              out_wdata  <= in_addr;
              out_reg_wr <= in_mem ? 1'b0 : in_reg_wr;
              out_pc     <= in_pc;
              out_exc    <= in_mem ? EXC_MISALGN : EXC_NONE;
            end else begin
              cap_op     <= in_memop;
              cap_addr   <= in_addr;
              cap_wdata  <= in_wdata;
              cap_rd     <= in_rd;
              cap_reg_wr <= in_reg_wr;
              cap_pc     <= in_pc;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            if (op_store(cap_op)) begin
              out_valid  <= 1'b1;
              out_rd     <= cap_rd;
              out_wdata  <= cap_addr;
              out_reg_wr <= 1'b0;
              out_pc     <= cap_pc;
              out_exc    <= EXC_NONE;
              state      <= IDLE;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (dmem_resp_valid) begin
            out_valid  <= 1'b1;
            out_rd     <= cap_rd;
            out_wdata  <= load_value;
            out_reg_wr <= cap_reg_wr;
            out_pc     <= cap_pc;
            out_exc    <= EXC_NONE;
            state      <= IDLE;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            // Abandon the load; a response arriving later lands in IDLE and is dropped.
            out_valid  <= 1'b1;
            out_rd     <= cap_rd;
            out_wdata  <= cap_addr;
            out_reg_wr <= 1'b0;
            out_pc     <= cap_pc;
            out_exc    <= EXC_TIMEOUT;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fwd_valid       = out_valid & out_reg_wr & (out_rd != '0);
  assign fwd_rd          = out_rd;
  assign fwd_value       = out_wdata;
  assign load_pending    = (state != IDLE) & op_load(cap_op) & (cap_rd != '0);
  assign load_pending_rd = cap_rd;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit; expected retirements go to a scoreboard queue checked by a monitor.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_memop;
  logic [31:0] in_addr, in_wdata, in_pc;
  logic [4:0]  in_rd;
  logic        in_reg_wr;
  logic        in_ready;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        out_valid, out_reg_wr, fwd_valid, load_pending;
  logic [4:0]  out_rd, fwd_rd, load_pending_rd;
  logic [31:0] out_wdata, out_pc, fwd_value;
  logic [1:0]  out_exc;

  mem_stage_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_memop(in_memop), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_reg_wr(in_reg_wr), .in_pc(in_pc), .in_ready(in_ready),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .out_valid(out_valid), .out_rd(out_rd), .out_wdata(out_wdata), .out_reg_wr(out_reg_wr),
    .out_pc(out_pc), .out_exc(out_exc), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_value(fwd_value), .load_pending(load_pending), .load_pending_rd(load_pending_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        reg_wr;
    logic [31:0] pc;
    logic [1:0]  exc;
    int          lo;
    int          hi;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input logic [4:0] rd, input logic [31:0] wd, input logic cw,
                            input logic rw, input logic [31:0] pc, input logic [1:0] exc,
                            input int lo, input int hi);
    exp_t e;
    e.rd = rd; e.wdata = wd; e.chk_wdata = cw; e.reg_wr = rw;
    e.pc = pc; e.exc = exc; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out_valid: got out_valid=1 rd=%0d, required no output (cyc %0d)", out_rd, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_reg_wr", 32'(out_reg_wr), 32'(e.reg_wr));
        chk("out_pc", out_pc, e.pc);
        chk("out_exc", 32'(out_exc), 32'(e.exc));
        chk("fwd_valid", 32'(fwd_valid), 32'(e.reg_wr && (e.rd != 5'd0)));
        chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
        if (e.chk_wdata) begin
          chk("out_wdata", out_wdata, e.wdata);
          chk("fwd_value", fwd_value, e.wdata);
        end
        n_chk++;
        if (cyc < e.lo || cyc > e.hi) begin
          n_err++;
          $display("FAIL out_timing: got cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
  end

  // Called at a negedge with the stage idle; returns one cycle later with in_valid dropped.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic [31:0] pc);
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_memop = op; in_addr = addr; in_wdata = wd;
    in_rd = rd; in_reg_wr = rw; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_none(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input logic rw, input logic [31:0] pc);
    expect_out(rd, addr, 1'b1, rw, pc, 2'd0, cyc + 1, cyc + 1);
    issue(op, addr, 32'hDEAD_BEEF, rd, rw, pc);
  endtask

  task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] expv, input logic [31:0] pc);
    dmem_req_ready = 1'b1;
    expect_out(rd, expv, 1'b1, 1'b1, pc, 2'd0, cyc + 3, cyc + 3);
    issue(op, addr, 32'h0, rd, 1'b1, pc);
    chk("ld_req_valid", 32'(dmem_req_valid), 32'd1);
    chk("ld_req_we", 32'(dmem_req_we), 32'd0);
    chk("ld_req_addr", dmem_req_addr, {addr[31:2], 2'b00});
    chk("ld_in_ready_req", 32'(in_ready), 32'd0);
    chk("ld_pending_req", 32'(load_pending), 32'(rd != 5'd0));
    chk("ld_pending_rd", 32'(load_pending_rd), 32'(rd));
    @(negedge clk);
    chk("ld_req_valid_wait", 32'(dmem_req_valid), 32'd0);
    chk("ld_in_ready_wait", 32'(in_ready), 32'd0);
    chk("ld_pending_wait", 32'(load_pending), 32'(rd != 5'd0));
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = rdata;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    chk("ld_in_ready_done", 32'(in_ready), 32'd1);
    chk("ld_pending_done", 32'(load_pending), 32'd0);
  endtask

  task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] pc, input int nwait,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    dmem_req_ready = 1'b0;
    expect_out(rd, 32'h0, 1'b0, 1'b0, pc, 2'd0, cyc + 2 + nwait, cyc + 2 + nwait);
    issue(op, addr, wd, rd, 1'b1, pc);
    for (int i = 0; i <= nwait; i++) begin
      if (i == nwait) dmem_req_ready = 1'b1;
      chk("st_req_valid", 32'(dmem_req_valid), 32'd1);
      chk("st_req_we", 32'(dmem_req_we), 32'd1);
      chk("st_req_addr", dmem_req_addr, {addr[31:2], 2'b00});
      chk("st_req_be", 32'(dmem_req_be), 32'(exp_be));
      chk("st_req_wdata", dmem_req_wdata, exp_wd);
      chk("st_pending", 32'(load_pending), 32'd0);
      @(negedge clk);
    end
    chk("st_req_valid_done", 32'(dmem_req_valid), 32'd0);
    chk("st_in_ready_done", 32'(in_ready), 32'd1);
  endtask

  task automatic do_misal(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] pc);
    dmem_req_ready = 1'b1;
    expect_out(rd, 32'h0, 1'b0, 1'b0, pc, 2'd1, cyc + 1, cyc + 1);
    issue(op, addr, 32'h0, rd, 1'b1, pc);
    chk("mis_no_req", 32'(dmem_req_valid), 32'd0);
    chk("mis_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    reset = 1'b0; in_valid = 1'b0; in_memop = 4'd0; in_addr = '0; in_wdata = '0;
    in_rd = '0; in_reg_wr = 1'b0; in_pc = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exc", 32'(out_exc), 32'd0);
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_load_pending", 32'(load_pending), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_none(4'd0,  32'h0000_1234, 5'd5, 1'b1, 32'h100);
    do_none(4'd12, 32'h0000_0777, 5'd3, 1'b1, 32'h104);
    do_none(4'd0,  32'h0000_0055, 5'd0, 1'b1, 32'h108);
    do_none(4'd0,  32'h0000_0066, 5'd4, 1'b0, 32'h10C);
    @(negedge clk);

    do_load(4'd1, 32'h0000_0103, 5'd7,  32'h80FF_0000, 32'hFFFF_FF80, 32'h200);
    do_load(4'd4, 32'h0000_0101, 5'd8,  32'h0000_9A00, 32'h0000_009A, 32'h204);
    do_load(4'd2, 32'h0000_0102, 5'd9,  32'h8001_0000, 32'hFFFF_8001, 32'h208);
    do_load(4'd5, 32'h0000_0102, 5'd10, 32'h8001_0000, 32'h0000_8001, 32'h20C);
    do_load(4'd3, 32'h0000_0104, 5'd11, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h210);
    do_load(4'd1, 32'h0000_0100, 5'd0,  32'h0000_007F, 32'h0000_007F, 32'h214);

    do_store(4'd7, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 32'h300, 3, 4'b1100, 32'hABCD_ABCD);
    do_store(4'd7, 32'h0000_0200, 32'h1111_2222, 5'd9, 32'h304, 0, 4'b0011, 32'h2222_2222);
    do_store(4'd6, 32'h0000_0201, 32'h0000_005A, 5'd2, 32'h308, 1, 4'b0010, 32'h5A5A_5A5A);
    do_store(4'd8, 32'h0000_0204, 32'h1234_5678, 5'd2, 32'h30C, 0, 4'b1111, 32'h1234_5678);

    do_misal(4'd3, 32'h0000_0006, 5'd12, 32'h400);
    do_misal(4'd7, 32'h0000_0203, 5'd13, 32'h404);
    do_misal(4'd5, 32'h0000_0041, 5'd14, 32'h408);

    // Load whose response never arrives.
    dmem_req_ready = 1'b1;
    a = cyc;
    expect_out(5'd15, 32'h0, 1'b0, 1'b0, 32'h500, 2'd2, a + 257, a + 259);
    issue(4'd5, 32'h0000_0040, 32'h0, 5'd15, 1'b1, 32'h500);
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("timeout_retired", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("timeout_in_ready", 32'(in_ready), 32'd1);
    do_none(4'd0, 32'h0000_0ABC, 5'd6, 1'b1, 32'h504);

    // Reset in the middle of a load wait.
    dmem_req_ready = 1'b1;
    issue(4'd3, 32'h0000_0080, 32'h0, 5'd16, 1'b1, 32'h600);
    repeat (4) @(negedge clk);
    chk("wait_load_pending", 32'(load_pending), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_load_pending", 32'(load_pending), 32'd0);
    chk("midrst_req_valid", 32'(dmem_req_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h1357_9BDF;
    repeat (2) @(negedge clk);
    dmem_resp_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_resp_in_ready", 32'(in_ready), 32'd1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Consumer end of the AGEX→MEM pipeline latch.
- Takes each executed instruction (ALU result or effective address, store data, destination register) and completes it:
  - loads and stores go through a valid/ready data-memory port;
  - everything else passes straight through.
- Produces the registered MEM latch for WB, the stall signal back to AGEX, and the forwarding and load-pending information carried on from_MEM_to_AGEX.

Parameters:
- DBITS, 32, data and address width.
- REGNOBITS, 5, register-number width.
- TIMEOUT, 255, maximum cycles spent in WAIT_RESP before the access is abandoned.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  AGEX latch holds a valid instruction
- in_memop  in  4  0=NONE, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW; 9..15 are treated as NONE
- in_addr  in  DBITS  arith result; this is the effective address for memory ops
- in_wdata  in  DBITS  store data (rs2 value)
- in_rd  in  REGNOBITS  destination register
- in_reg_wr  in  1  instruction writes rd
- in_pc  in  DBITS  PC, carried to WB
- in_ready  out  1  stage can accept this cycle; when 0, AGEX holds its latch
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  DBITS  word-aligned address ({addr[31:2],2'b00})
- dmem_req_wdata  out  DBITS  store data replicated into byte lanes
- dmem_req_be  out  4  byte enables
- dmem_resp_valid  in  1  load data valid
- dmem_resp_rdata  in  DBITS  load data word
- out_valid  out  1  MEM latch valid
- out_rd  out  REGNOBITS  MEM latch rd
- out_wdata  out  DBITS  value written back
- out_reg_wr  out  1  write-back enable
- out_pc  out  DBITS  MEM latch PC
- out_exc  out  2  0 = none, 1 = misaligned, 2 = timeout
- fwd_valid  out  1  out_valid & out_reg_wr & (out_rd != 0)
- fwd_rd  out  REGNOBITS  = out_rd
- fwd_value  out  DBITS  = out_wdata
- load_pending  out  1  a load to rd != 0 is in flight
- load_pending_rd  out  REGNOBITS  rd of the in-flight load

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = IDLE, wait counter = 0.
  - All out_* signals, dmem_req_valid and load_pending = 0; in_ready = 1.
- Only the FSM state, the captured request registers and the out_* latch are registered. All other outputs are derived combinationally from them.
- FSM states: IDLE, REQ, WAIT_RESP. in_ready = (state == IDLE).
- IDLE, in_valid, NONE op:
  - Next cycle: out_valid = 1, out_wdata = in_addr, out_reg_wr = in_reg_wr. Latency 1. State stays IDLE.
- IDLE, in_valid, misaligned memory op:
  - Misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - No memory request is issued.
  - Next cycle: out_valid = 1, out_exc = 1, out_reg_wr = 0.
- IDLE, in_valid, aligned memory op:
  - Capture op, addr, wdata, rd, pc; go to REQ.
  - out_valid = 0 while the access is outstanding.
- REQ:
  - dmem_req_valid = 1 and request fields held stable until dmem_req_ready.
  - Store handshake: next cycle out_valid = 1, out_reg_wr = 0; back to IDLE.
  - Load handshake: go to WAIT_RESP with counter = 0.
- Store lane formatting:
  - SB: wdata = {4{b}}, be = 1 << addr[1:0].
  - SH: wdata = {2{h}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: be = 4'b1111.
- WAIT_RESP, dmem_resp_valid:
  - Extract byte/half selected by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Next cycle: out_valid = 1, out_wdata = extracted value, out_reg_wr = captured reg_wr; back to IDLE.
- WAIT_RESP, no response:
  - Counter increments each cycle.
  - At counter == TIMEOUT: out_valid = 1, out_exc = 2, out_reg_wr = 0; back to IDLE.
- dmem_resp_valid outside WAIT_RESP is ignored.
- Minimum load latency: accept at T → request at T+1 (ready) → response at T+2 → out_valid at T+3.
- out_valid is a one-cycle pulse per retired instruction. WB never backpressures.
- load_pending = (state != IDLE) & captured op is a load & captured rd != 0.
- in_valid while in_ready = 0 is not a protocol error; the input is simply not consumed.
- Reset asserted mid-access: FSM and outputs clear immediately; the abandoned transaction's response is ignored.

Test Plan:
- NONE op: in_addr = 0x0000_1234, rd = 5, reg_wr = 1 → one cycle later out_valid = 1, out_wdata = 0x1234, fwd_valid = 1, fwd_rd = 5.
- LB at addr 0x103, resp_rdata = 0x80FF_0000, req_ready = 1, response 1 cycle after handshake → out_wdata = 0xFFFF_FF80, out_valid 3 cycles after accept; in_ready = 0 and load_pending = 1 throughout.
- SH at addr 0x202, wdata = 0xABCD, req_ready held low 3 cycles → req fields stable, be = 4'b1100, req_wdata = 0xABCD_ABCD, out_valid 1 cycle after handshake with out_reg_wr = 0.
- LW at addr 0x6 → no dmem_req_valid; next cycle out_exc = 1, out_reg_wr = 0.
- LHU at 0x40, response never arrives → out_exc = 2 after 255 wait cycles; returns to IDLE and accepts the next instruction.
- Reset pulled low in WAIT_RESP → out_valid = 0, in_ready = 1 immediately; a late dmem_resp_valid after release produces no output.
